// File: rtl/ahb_sram_slave_if.sv
`default_nettype none
// ============================================================================
//  Module      : ahb_sram_slave_if
//  Description : AHB-Lite bus bundle between the data-side master (through the
//                interconnect) and the SRAM slave.
//                master modport: drives HSEL/HADDR/HTRANS/HWRITE/HSIZE/HWDATA
//                               and the bus-wide HREADY; observes the response.
//                slave modport : the mirror image; drives HRDATA, HREADYOUT,
//                               HRESP.
//  Revision    : 1.0 - initial release
// ============================================================================
interface ahb_sram_slave_if;
  logic        HSEL;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [31:0] HWDATA;
  logic        HREADY;
  logic [31:0] HRDATA;
  logic        HREADYOUT;
  logic        HRESP;

  modport master (
    output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADY,
    input  HRDATA, HREADYOUT, HRESP
  );

  modport slave (
    input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADY,
    output HRDATA, HREADYOUT, HRESP
  );
endinterface
`default_nettype wire

// File: rtl/ahb_sram_slave.sv
`default_nettype none
// ============================================================================
//  Module      : ahb_sram_slave
//  Description : AHB-Lite slave word-organised SRAM with programmable wait
//                states and the two-cycle ERROR response for out-of-window,
//                oversized or misaligned transfers.
//  Ports       : HCLK     - clock, all state changes on the rising edge
//                HRESETn  - synchronous reset, active low
//                bus      - AHB-Lite slave modport (address/data phase inputs,
//                           HRDATA / HREADYOUT / HRESP outputs)
//  Revision    : 1.0 - initial release
// ============================================================================
module ahb_sram_slave #(
  parameter int unsigned ADDR_WIDTH  = 10,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic             HCLK,
  input  logic             HRESETn,
  ahb_sram_slave_if.slave  bus
);

  localparam int unsigned DEPTH       = 1 << ADDR_WIDTH;
  // Byte size of the decoded window, one bit wider than the address so the
  // comparison cannot wrap.
  localparam logic [32:0] C_WINDOW    = 33'd4 << ADDR_WIDTH;
  localparam logic [3:0]  C_WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_WAIT = 3'd1;
  localparam logic [2:0] S_DATA = 3'd2;
  localparam logic [2:0] S_ERR1 = 3'd3;
  localparam logic [2:0] S_ERR2 = 3'd4;

  logic [2:0]            state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [ADDR_WIDTH+1:0] off_q, off_d;
  logic                  write_q, write_d;
  logic [1:0]            size_q, size_d;

  logic [31:0]           mem_q [DEPTH];

  // --------------------------------------------------------------------------
  // Address-phase decode
  // --------------------------------------------------------------------------
  logic [31:0] w_off;
  logic        w_accept;
  logic        w_range_err;
  logic        w_size_err;
  logic        w_align_err;
  logic        w_error;
  logic        w_unused;

  assign w_off       = bus.HADDR - BASE_ADDR;
  assign w_accept    = bus.HSEL & bus.HTRANS[1] & bus.HREADY;
  // An address below the base wraps w_off to a huge value, but keep the
  // explicit test so the intent is obvious.
  assign w_range_err = (bus.HADDR < BASE_ADDR) | ({1'b0, w_off} >= C_WINDOW);
  assign w_size_err  = bus.HSIZE[2] | (bus.HSIZE[1:0] == 2'b11);
  assign w_align_err = ((bus.HSIZE == 3'd1) & bus.HADDR[0]) |
                       ((bus.HSIZE == 3'd2) & (bus.HADDR[1:0] != 2'b00));
  assign w_error     = w_range_err | w_size_err | w_align_err;
  // HTRANS[0] only separates NONSEQ/SEQ and IDLE/BUSY, which are handled alike.
  assign w_unused    = bus.HTRANS[0];

  // --------------------------------------------------------------------------
  // Next-state logic. IDLE, DATA and ERR2 all end a data phase with
  // HREADYOUT=1, so they share the same accept handling.
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    off_d   = off_q;
    write_d = write_q;
    size_d  = size_q;
    case (state_q)
      S_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = S_DATA;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_ERR1: begin
        state_d = S_ERR2;
      end
      default: begin
        state_d = S_IDLE;
        if (w_accept) begin
          off_d   = w_off[ADDR_WIDTH+1:0];
          write_d = bus.HWRITE;
          size_d  = bus.HSIZE[1:0];
          if (w_error) begin
            state_d = S_ERR1;
          end else if (WAIT_STATES == 0) begin
            state_d = S_DATA;
          end else begin
            state_d = S_WAIT;
            cnt_d   = C_WAIT_LOAD;
          end
        end
      end
    endcase
  end

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      off_q   <= '0;
      write_q <= 1'b0;
      size_q  <= 2'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      off_q   <= off_d;
      write_q <= write_d;
      size_q  <= size_d;
    end
  end

  // --------------------------------------------------------------------------
  // Memory array. Writes commit at the edge that ends DATA; a reset at that
  // edge drops the write. The array itself is never cleared.
  // --------------------------------------------------------------------------
  logic [ADDR_WIDTH-1:0] w_idx;
  logic [3:0]            w_be;
  logic                  w_commit;

  assign w_idx    = off_q[ADDR_WIDTH+1:2];
  assign w_commit = (state_q == S_DATA) & write_q & HRESETn;

  always_comb begin
    case (size_q)
      2'd0:    w_be = 4'b0001 << off_q[1:0];
      2'd1:    w_be = off_q[1] ? 4'b1100 : 4'b0011;
      default: w_be = 4'b1111;
    endcase
  end

  always_ff @(posedge HCLK) begin
    if (w_commit) begin
      for (int i = 0; i < 4; i++) begin
        if (w_be[i]) begin
          mem_q[w_idx][8*i +: 8] <= bus.HWDATA[8*i +: 8];
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Response outputs, decoded straight from the state
  // --------------------------------------------------------------------------
  assign bus.HREADYOUT = !((state_q == S_WAIT) || (state_q == S_ERR1));
  assign bus.HRESP     = (state_q == S_ERR1) || (state_q == S_ERR2);
  assign bus.HRDATA    = ((state_q == S_DATA) && !write_q) ? mem_q[w_idx] : 32'h0;

endmodule
`default_nettype wire
